// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD combinational read ports, one writeback port and a per-register
// busy scoreboard. Optional macro REGFILE_BYPASS_EN enables write-through forwarding on reads.
module regfile_scoreboard #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NREG          = 32,
  parameter int unsigned NRD           = 2,
  parameter bit          HARDWIRE_ZERO = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]         rd_data,
  output logic [NRD-1:0]              rd_busy,
  input  logic                        wr_en,
  input  logic [$clog2(NREG)-1:0]     wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  input  logic                        rsv_en,
  input  logic [$clog2(NREG)-1:0]     rsv_addr,
  output logic                        rsv_conflict,
  output logic [NREG-1:0]             busy_vec,
  output logic [$clog2(NREG):0]       busy_count
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            wr_ok;
  logic            rsv_ok;

  // Register 0 is inert for writes and reservations when hardwired to zero
  assign wr_ok  = wr_en  && !(HARDWIRE_ZERO && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !(HARDWIRE_ZERO && (rsv_addr == '0));

  // A writeback releasing the same register this cycle is not a conflict
  assign rsv_conflict = rsv_ok && busy_q[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));

  // Next busy flags: release first so a same-address reservation wins
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    count_d = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      count_d = count_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign busy_vec   = busy_q;
  assign busy_count = count_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero;
    assign addr = rd_addr[i*AW +: AW];
    assign zero = HARDWIRE_ZERO && (addr == '0);
`ifdef REGFILE_BYPASS_EN
    logic fwd;
    logic rsv_same;
    assign fwd      = wr_ok && (wr_addr == addr);
    assign rsv_same = rsv_ok && (rsv_addr == addr);
    assign rd_data[i*XLEN +: XLEN] = zero ? '0 : (fwd ? wr_data : regs_q[addr]);
    // Forwarded writeback clears busy unless the same register is re-reserved this cycle
    assign rd_busy[i] = !zero && busy_q[addr] && !(fwd && !rsv_same);
`else
    assign rd_data[i*XLEN +: XLEN] = zero ? '0 : regs_q[addr];
    assign rd_busy[i]              = !zero && busy_q[addr];
`endif
  end

endmodule
